// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, opcode/funct
// constants, datapath select codes and the instruction-class record.
package mc_defs;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} mcState_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b110;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // Exactly one field is set for any legal instruction; none for an illegal one.
  typedef struct packed {
    logic rType;
    logic jump;
    logic jal;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
  } instrClass_t;

  function automatic logic [2:0] functToAluCtr(input logic [5:0] funct);
    case (funct)
      FN_SUB, FN_SUBU: return ALU_SUB;
      FN_AND:          return ALU_AND;
      FN_OR:           return ALU_OR;
      FN_SLT:          return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_decode.sv
// Combinational instruction classifier: maps op/funct to a one-hot class record and
// flags anything the controller cannot execute.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output instrClass_t instrClass,
  output logic        illegal
);

  always_comb begin
    instrClass = '0;
    illegal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_SLT:           instrClass.rType = 1'b1;
          FN_JR:                           instrClass.jr    = 1'b1;
          FN_SLL:                          instrClass.nop   = 1'b1;
          default:                         illegal          = 1'b1;
        endcase
      end
      OP_J:    instrClass.jump = 1'b1;
      OP_JAL:  instrClass.jal  = 1'b1;
      OP_BEQ:  instrClass.beq  = 1'b1;
      OP_ORI:  instrClass.ori  = 1'b1;
      OP_LUI:  instrClass.lui  = 1'b1;
      OP_LW:   instrClass.lw   = 1'b1;
      OP_SW:   instrClass.sw   = 1'b1;
      default: illegal         = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with memory handshakes, bus timeout and illegal-op flagging.
// Optional MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mc_controller
  import mc_defs::*;
#(
  parameter int ALUCTR_W    = 3,
  parameter int NPC_SEL_W   = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic                 mdr_we,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src,
  output logic                 ext_op,
  output logic                 imm_high,
  output logic [ALUCTR_W-1:0]  alu_ctr,
  output logic [NPC_SEL_W-1:0] npc_sel,
  output logic                 illegal,
  output logic                 bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instr_cnt
`endif
);

  localparam int CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CntW-1:0] TmoLast = (TIMEOUT_CYC > 0) ? CntW'(TIMEOUT_CYC - 1) : '0;

  mcState_t        state, nextState;
  logic [CntW-1:0] waitCnt;
  instrClass_t     cls;
  logic            decIllegal;
  logic            waiting, timeout;

  mc_decode uDecode (
    .op         (op),
    .funct      (funct),
    .instrClass (cls),
    .illegal    (decIllegal)
  );

  // The current cycle is the TIMEOUT_CYC-th consecutive unanswered request cycle.
  assign waiting = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign timeout = waiting && (TIMEOUT_CYC != 0) && (waitCnt == TmoLast);

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    mdr_we     = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    imm_high   = 1'b0;
    alu_ctr    = ALUCTR_W'(ALU_ADD);
    npc_sel    = NPC_SEL_W'(NPC_PC4);
    illegal    = 1'b0;
    bus_err    = 1'b0;
    nextState  = state;
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            nextState = DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end
        end
        DECODE: begin
          nextState = FETCH;
          if (decIllegal) begin
            illegal = 1'b1;
          end else if (cls.jump || cls.jal) begin
            pc_we   = 1'b1;
            npc_sel = NPC_SEL_W'(NPC_JUMP);
            if (cls.jal) begin
              reg_we     = 1'b1;
              reg_dst    = REGDST_RA;
              mem_to_reg = M2R_PC;
            end
          end else if (cls.jr) begin
            pc_we   = 1'b1;
            npc_sel = NPC_SEL_W'(NPC_JR);
          end else if (!cls.nop) begin
            nextState = EXEC;
          end
        end
        EXEC: begin
          nextState = FETCH;
          if (cls.rType) begin
            alu_ctr   = ALUCTR_W'(functToAluCtr(funct));
            nextState = WB;
          end else if (cls.ori) begin
            alu_src   = 1'b1;
            alu_ctr   = ALUCTR_W'(ALU_OR);
            nextState = WB;
          end else if (cls.lui) begin
            imm_high  = 1'b1;
            alu_src   = 1'b1;
            nextState = WB;
          end else if (cls.lw || cls.sw) begin
            alu_src   = 1'b1;
            ext_op    = 1'b1;
            nextState = MEM;
          end else if (cls.beq) begin
            alu_ctr = ALUCTR_W'(ALU_SUB);
            npc_sel = NPC_SEL_W'(NPC_BRANCH);
            pc_we   = alu_zero;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          mem_we   = cls.sw;
          if (dmem_ready) begin
            if (cls.lw) begin
              mdr_we    = 1'b1;
              nextState = WB;
            end else begin
              nextState = FETCH;
            end
          end else if (timeout) begin
            bus_err   = 1'b1;
            nextState = FETCH;
          end
        end
        WB: begin
          reg_we     = 1'b1;
          reg_dst    = cls.rType ? REGDST_RD : REGDST_RT;
          mem_to_reg = cls.lw ? M2R_MDR : M2R_ALU;
          nextState  = FETCH;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  // A timeout re-enters FETCH, so clearing the counter on it also restarts the wait window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (waiting && !timeout && (TIMEOUT_CYC != 0)) begin
        waitCnt <= waitCnt + CntW'(1);
      end else begin
        waitCnt <= '0;
      end
    end
  end

`ifdef MC_PERF_CNT_EN
  logic retire;

  assign retire = (state != FETCH) && (nextState == FETCH) && !illegal && !bus_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle successor to the single-cycle MIPS main decoder. A 5-state FSM (FETCH/DECODE/EXEC/MEM/WB) sequences per-state control strobes for a shared-datapath CPU. It adds req/ready handshakes to instruction and data memory, a bus timeout, and illegal-opcode flagging. It sits between the IR/ALU-zero flag and every datapath enable and mux select.

Parameters:
ALUCTR_W, 3, width of alu_ctr (000 add, 001 sub, 010 or, 011 and, 100 slt)
NPC_SEL_W, 3, width of npc_sel (000 pc+4, 001 branch, 010 j/jal, 110 jr)
TIMEOUT_CYC, 16, max wait cycles for mem ready; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag (EXEC)
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  fetch request
dmem_req  out  1  data access request
mem_we  out  1  data write strobe (with dmem_req)
ir_we  out  1  IR load
pc_we  out  1  PC load
reg_we  out  1  register file write
mdr_we  out  1  memory data register load
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src  out  1  0 rt, 1 extended imm
ext_op  out  1  1 sign-extend, 0 zero-extend
imm_high  out  1  lui: imm<<16
alu_ctr  out  ALUCTR_W  ALU op
npc_sel  out  NPC_SEL_W  next-PC source
illegal  out  1  one-cycle pulse on undecodable instr
bus_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset: state=FETCH, wait counter=0, every output 0. Reset mid-handshake drops req the next cycle; no write completes.
- Strobes are combinational from the registered state plus decoded IR. Only state and the wait counter are registered.
- FETCH: imem_req=1. On imem_ready: ir_we=1, pc_we=1, npc_sel=000, go to DECODE. Otherwise hold.
- DECODE:
  - j: pc_we=1, npc_sel=010, go to FETCH.
  - jal: same as j, plus reg_we=1, reg_dst=10, mem_to_reg=10 (PC already holds pc+4).
  - jr: pc_we=1, npc_sel=110, go to FETCH.
  - sll/nop (funct 000000): go to FETCH, no writes.
  - Illegal op/funct: illegal=1, go to FETCH, no writes.
  - Otherwise go to EXEC.
- EXEC:
  - R-type (add/addu 100000/100001, sub/subu 100010/100011, and 100100, or 100101, slt 101010): alu_src=0, alu_ctr per funct, go to WB.
  - ori: alu_src=1, ext_op=0, alu_ctr=or, go to WB.
  - lui: imm_high=1, alu_src=1, go to WB.
  - lw/sw: alu_src=1, ext_op=1, alu_ctr=add, go to MEM.
  - beq: alu_ctr=sub, npc_sel=001, pc_we=alu_zero, go to FETCH.
- MEM: dmem_req=1, mem_we=1 for sw.
  - lw: on dmem_ready, mdr_we=1, go to WB.
  - sw: on dmem_ready, go to FETCH.
  - req stays high until ready.
- WB: reg_we=1; reg_dst=01 for R-type, 00 otherwise; mem_to_reg=01 for lw, else 00. Go to FETCH.
- Cycle counts with zero-wait memory: j/jr/nop 2; beq 3; R/ori/lui/sw 4; lw 5. Each wait cycle adds 1.
- Timeout:
  - Counter increments each cycle req is high and ready is low, and clears on state change.
  - When it reaches TIMEOUT_CYC (nonzero), bus_err pulses and state goes to FETCH. PC is unchanged if the timeout hits in FETCH; no write occurs.
  - If ready and timeout coincide, ready wins.
- Branch decision uses alu_zero only in EXEC; it is ignored elsewhere.

Optional Feature:
MC_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[31:0] (+1 every non-reset cycle) and instr_cnt[31:0] (+1 on each transition into FETCH from DECODE/EXEC/MEM/WB, excluding illegal/timeout). Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mc_defs: state encoding, opcode/funct constants, alu_ctr/npc_sel/reg_dst/mem_to_reg codes.
- One sub-module, mc_decode: combinational op/funct to instruction-class one-hots plus illegal.
- The FSM, wait counter and strobe generation stay in mc_controller.

Test Plan:
- Reset held 3 cycles mid-MEM of sw → next cycle state FETCH, all outputs 0, mem_we never 1 after reset.
- add (op 000000, funct 100000), ready tied 1 → imem_req, DECODE, EXEC alu_ctr=000, WB reg_we=1 reg_dst=01; 4 cycles total.
- lw with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, mdr_we pulses once, WB mem_to_reg=01; 8 cycles total.
- beq with alu_zero=1, then alu_zero=0 → pc_we=1 npc_sel=001 in EXEC, then pc_we=0; both take 3 cycles.
- jal → DECODE asserts pc_we, reg_we, reg_dst=10, mem_to_reg=10 together; 2 cycles.
- imem_ready held 0 with TIMEOUT_CYC=16 → bus_err pulses after 16 wait cycles, FETCH re-entered; op=111111 → illegal pulse, no reg_we/mem_we.
